// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: direction-counter encodings
// and the prediction rule applied to a BTB entry.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    // Non-geometry part of an entry; the top wraps it with tag/target.
    typedef struct packed {
        logic valid;
        ctr_t ctr;
        logic jmp;
    } bp_meta_t;

    // Jumps are always taken; branches follow the counter's upper bit.
    function automatic logic bp_pred_dir(input logic jmp, input ctr_t ctr);
        return jmp | ctr[1];
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating counter next-state: step towards taken or not-taken,
// holding at either end.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t ctr_nxt
);

    always_comb begin
        ctr_nxt = ctr;
        if (taken && ctr != CTR_ST)
            ctr_nxt = ctr + 2'd1;
        else if (!taken && ctr != CTR_SNT)
            ctr_nxt = ctr - 2'd1;
    end

endmodule

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters and a
// zero-latency mispredict redirect. Optional counters under BP_STATS_EN.
module bp_btb
    import bp_pkg::*;
#(
    parameter int   XLEN         = 32,
    parameter int   ENTRIES      = 16,
    parameter ctr_t CTR_ALLOC_BR = CTR_WT,
    localparam int  IDX_W        = $clog2(ENTRIES),
    localparam int  TAG_W        = XLEN - 2 - IDX_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    output logic [XLEN-1:0] if_pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            ex_redirect,
    output logic [XLEN-1:0] ex_redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     stat_ctrl,
    output logic [31:0]     stat_mispred
`endif
);

    typedef struct packed {
        bp_meta_t         meta;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
    } entry_t;

    entry_t tbl [ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    entry_t           if_e, ex_e;
    logic             if_hit, ex_hit;
    logic             act_taken;
    logic [XLEN-1:0]  act_next;
    ctr_t             ctr_upd;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX_W+2];

    // Lookup reads the registered table, so a same-cycle update is not seen.
    assign if_e           = tbl[if_idx];
    assign if_hit         = if_e.meta.valid && (if_e.tag == if_tag);
    assign if_pred_taken  = if_hit && bp_pred_dir(if_e.meta.jmp, if_e.meta.ctr);
    assign if_pred_target = if_pred_taken ? if_e.target : if_pc + XLEN'(4);

    assign act_taken      = ex_is_jump || (ex_is_branch && ex_taken);
    assign act_next       = act_taken ? ex_target : ex_pc + XLEN'(4);
    assign ex_redirect    = ex_valid && (act_next != ex_pred_target);
    assign ex_redirect_pc = act_next;

    assign ex_e   = tbl[ex_idx];
    assign ex_hit = ex_e.meta.valid && (ex_e.tag == ex_tag);

    bp_sat_ctr u_ctr (
        .ctr     (ex_e.meta.ctr),
        .taken   (ex_taken),
        .ctr_nxt (ctr_upd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i].meta.valid <= 1'b0;
                tbl[i].meta.ctr   <= CTR_SNT;
            end
        end else if (ex_valid) begin
            if (ex_is_jump) begin
                tbl[ex_idx] <= '{meta: '{valid: 1'b1, ctr: CTR_ST, jmp: 1'b1},
                                 tag: ex_tag, target: ex_target};
            end else if (ex_is_branch) begin
                if (ex_hit) begin
                    tbl[ex_idx].meta.ctr <= ctr_upd;
                    if (ex_taken)
                        tbl[ex_idx].target <= ex_target;
                end else if (ex_taken) begin
                    tbl[ex_idx] <= '{meta: '{valid: 1'b1, ctr: CTR_ALLOC_BR, jmp: 1'b0},
                                     tag: ex_tag, target: ex_target};
                end
            end else if (ex_hit) begin
                // A non-control instruction matched: the entry is a stale alias.
                tbl[ex_idx].meta.valid <= 1'b0;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_ctrl    <= '0;
            stat_mispred <= '0;
        end else begin
            if (ex_valid && (ex_is_branch || ex_is_jump) && stat_ctrl != '1)
                stat_ctrl <= stat_ctrl + 32'd1;
            if (ex_redirect && stat_mispred != '1)
                stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{if_pc[1:0], ex_pc[1:0], ex_pred_taken};

endmodule

// File: tb/tb_bp_btb.sv
// Directed table-driven bench for bp_btb (ENTRIES=16, XLEN=32); checks the
// stat counters as well when built with BP_STATS_EN.
module tb_bp_btb;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        ex_redirect;
    logic [31:0] ex_redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_ctrl, stat_mispred;
    int          n_ctrl = 0, n_misp = 0;
`endif

    int checks = 0;
    int errors = 0;

    bp_btb #(.XLEN(32), .ENTRIES(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .if_pred_target (if_pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jump     (ex_is_jump),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .ex_redirect    (ex_redirect),
        .ex_redirect_pc (ex_redirect_pc)
`ifdef BP_STATS_EN
        ,
        .stat_ctrl      (stat_ctrl),
        .stat_mispred   (stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ipc;
        logic        v;
        logic [31:0] epc;
        logic        br, jmp, tkn;
        logic [31:0] tgt;
        logic        ppt;
        logic [31:0] ppc;
        logic        e_pt;
        logic [31:0] e_pc;
        logic        e_rd;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        if_pc          = t.ipc;
        ex_valid       = t.v;
        ex_pc          = t.epc;
        ex_is_branch   = t.br;
        ex_is_jump     = t.jmp;
        ex_taken       = t.tkn;
        ex_target      = t.tgt;
        ex_pred_taken  = t.ppt;
        ex_pred_target = t.ppc;
    endtask

    initial begin
        //              ipc  v  epc  br jp tk tgt     ppt ppc    e_pt e_pc  e_rd e_rpc
        vecs.push_back('{32'h100, 1, 32'h100, 0, 0, 0, 32'h0,   0, 32'h104, 0, 32'h104, 0, 32'h104});
        vecs.push_back('{32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80});
        vecs.push_back('{32'h100, 1, 32'h100, 1, 0, 0, 32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104});
        vecs.push_back('{32'h100, 1, 32'h100, 1, 0, 0, 32'h80,  0, 32'h104, 0, 32'h104, 0, 32'h104});
        vecs.push_back('{32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80});
        vecs.push_back('{32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80});
        vecs.push_back('{32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80});
        vecs.push_back('{32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80});
        vecs.push_back('{32'h100, 1, 32'h100, 1, 0, 0, 32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104});
        vecs.push_back('{32'h100, 0, 32'h100, 1, 0, 1, 32'h80,  0, 32'h104, 1, 32'h80,  0, 32'h80});
        vecs.push_back('{32'h100, 1, 32'h200, 0, 1, 0, 32'h400, 0, 32'h204, 1, 32'h80,  1, 32'h400});
        vecs.push_back('{32'h200, 1, 32'h200, 0, 1, 1, 32'h500, 1, 32'h400, 1, 32'h400, 1, 32'h500});
        vecs.push_back('{32'h200, 1, 32'h200, 0, 1, 1, 32'h500, 1, 32'h500, 1, 32'h500, 0, 32'h500});
        vecs.push_back('{32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80});
        vecs.push_back('{32'h100, 1, 32'h140, 1, 0, 1, 32'h90,  0, 32'h144, 1, 32'h80,  1, 32'h90});
        vecs.push_back('{32'h140, 1, 32'h140, 0, 0, 0, 32'h0,   1, 32'h90,  1, 32'h90,  1, 32'h144});
        vecs.push_back('{32'h140, 1, 32'h180, 1, 0, 1, 32'h60,  0, 32'h184, 0, 32'h144, 1, 32'h60});
        vecs.push_back('{32'h180, 1, 32'h180, 1, 0, 1, 32'h60,  1, 32'h60,  1, 32'h60,  0, 32'h60});
        vecs.push_back('{32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'h1234, 0, 32'h0, 0, 32'h0, 0, 32'h0});

        reset = 1'b1;
        drive('{32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h4, 0, 32'h0, 0, 32'h0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
`ifdef BP_STATS_EN
        #1;
        chk("stat_ctrl_reset", stat_ctrl, 32'd0);
        chk("stat_mispred_reset", stat_mispred, 32'd0);
`endif

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_pred_taken", i), {31'd0, if_pred_taken}, {31'd0, vecs[i].e_pt});
            chk($sformatf("v%0d_pred_target", i), if_pred_target, vecs[i].e_pc);
            chk($sformatf("v%0d_redirect", i), {31'd0, ex_redirect}, {31'd0, vecs[i].e_rd});
            chk($sformatf("v%0d_redirect_pc", i), ex_redirect_pc, vecs[i].e_rpc);
`ifdef BP_STATS_EN
            if (vecs[i].v && (vecs[i].br || vecs[i].jmp)) n_ctrl++;
            if (vecs[i].e_rd) n_misp++;
`endif
        end

        // Entry for 0x180 is trained; a mid-run reset must forget it.
        @(negedge clk);
        drive('{32'h180, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h4, 0, 32'h0, 0, 32'h0});
        #1;
        chk("pre_reset_hit", {31'd0, if_pred_taken}, 32'd1);
        chk("pre_reset_target", if_pred_target, 32'h60);
`ifdef BP_STATS_EN
        chk("stat_ctrl", stat_ctrl, n_ctrl);
        chk("stat_mispred", stat_mispred, n_misp);
`endif

        @(negedge clk);
        reset = 1'b1;
        drive('{32'h180, 1, 32'h180, 0, 0, 0, 32'h0, 1, 32'h60, 0, 32'h0, 0, 32'h0});
        #1;
        chk("reset_cycle_redirect", {31'd0, ex_redirect}, 32'd1);
        chk("reset_cycle_redirect_pc", ex_redirect_pc, 32'h184);

        @(negedge clk);
        reset = 1'b0;
        drive('{32'h180, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h4, 0, 32'h0, 0, 32'h0});
        #1;
        chk("post_reset_taken", {31'd0, if_pred_taken}, 32'd0);
        chk("post_reset_target", if_pred_target, 32'h184);
        if_pc = 32'h200;
        #1;
        chk("post_reset_200_target", if_pred_target, 32'h204);
`ifdef BP_STATS_EN
        chk("stat_ctrl_after_reset", stat_ctrl, 32'd0);
        chk("stat_mispred_after_reset", stat_mispred, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_btb.md
Name: bp_btb

Overview:
- Parametrised branch target buffer with 2-bit saturating-counter direction prediction for the 5-stage RISC-V pipeline.
- Lookup side: supplies a predicted next PC to IF in the same cycle as the PC is presented.
- Update side: takes resolution from the EX stage and raises a redirect on mispredict, so NPC flushes only on wrong predictions, not on every taken branch/jump.
- Replaces the always-not-taken EX-stage control-hazard policy.

Parameters:
- XLEN, 32, PC/target width.
- ENTRIES, 16, number of BTB entries; power of 2, at least 2.
- IDX_W, $clog2(ENTRIES), index width (derived, not overridden).
- TAG_W, XLEN-2-IDX_W, tag width (full upper PC bits).
- CTR_ALLOC_BR, 2'b10, counter value written when allocating a conditional branch.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- if_pc  in  XLEN  fetch PC.
- if_pred_taken  out  1  prediction for if_pc.
- if_pred_target  out  XLEN  predicted next PC (if_pc+4 when not taken).
- ex_valid  in  1  EX holds a real instruction (0 for bubble/flush).
- ex_pc  in  XLEN  PC of the instruction in EX.
- ex_is_branch  in  1  conditional branch.
- ex_is_jump  in  1  jal/jalr.
- ex_taken  in  1  resolved direction (ignored unless branch/jump; jump is always taken).
- ex_target  in  XLEN  resolved target.
- ex_pred_taken  in  1  prediction carried down the pipeline with this instruction.
- ex_pred_target  in  XLEN  predicted next PC carried down the pipeline.
- ex_redirect  out  1  mispredict; NPC must load ex_redirect_pc and flush IF/ID and ID/EX.
- ex_redirect_pc  out  XLEN  corrected next PC.

Behaviour:
- Each entry holds: valid, tag[TAG_W], target[XLEN], ctr[2], jmp flag. idx = pc[IDX_W+1:2], tag = pc[XLEN-1:IDX_W+2].
- Lookup is combinational from the registered table.
  - hit = valid[idx] && tag matches.
  - if_pred_taken = hit && (jmp || ctr[1]).
  - if_pred_target = if_pred_taken ? target : if_pc+4.
- Redirect is combinational, zero latency.
  - act_taken = ex_is_jump || (ex_is_branch && ex_taken).
  - act_next = act_taken ? ex_target : ex_pc+4.
  - ex_redirect = ex_valid && (act_next != ex_pred_target).
  - ex_redirect_pc = act_next.
- Table update happens at the clock edge when ex_valid=1. Let e = entry[idx(ex_pc)], with hit meaning e matches ex_pc.
  - Branch, hit: ctr saturating +1 if taken, -1 if not (11 stays 11, 00 stays 00). Target written if taken.
  - Branch, miss, taken: allocate (overwrite). valid=1, tag, target=ex_target, ctr=CTR_ALLOC_BR, jmp=0.
  - Branch, miss, not taken: no write.
  - Jump, hit or miss: write valid=1, tag, target=ex_target, jmp=1, ctr=2'b11. Covers a changed jalr target.
  - Neither branch nor jump, hit: clear valid (alias kill). ex_redirect fires as a result of the rule above.
  - ex_valid=0: no write, ex_redirect=0.
- Simultaneous lookup and update to the same idx: lookup returns pre-update contents. The write becomes visible the next cycle.
- Reset: on a reset cycle all valid and ctr bits are cleared to 0. After reset, every lookup misses (if_pred_taken=0, if_pred_target=if_pc+4), and ex_redirect follows its combinational rule. Reset mid-operation discards all learned state. No other reset-dependent state exists.
- Arithmetic: all PC+4 additions are XLEN-bit modulo; wrap at 2^XLEN is allowed.

Optional Feature:
- Macro BP_STATS_EN.
- When defined:
  - Adds outputs stat_ctrl[32] and stat_mispred[32]. Both clear on reset.
  - stat_ctrl increments each cycle with ex_valid && (ex_is_branch || ex_is_jump).
  - stat_mispred increments each cycle with ex_redirect.
  - Both saturate at 32'hFFFF_FFFF.
- When undefined: the ports and registers do not exist, and the rest of the behaviour is identical.

Decomposition:
- Shared package bp_pkg:
  - counter encodings CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - entry struct/typedef (valid, tag, target, ctr, jmp).
- One natural sub-module: bp_sat_ctr, the 2-bit saturating counter next-state (inc/dec, saturation). Instantiated per update path.

Test Plan:
- Reset, then if_pc=0x100 -> if_pred_taken=0, if_pred_target=0x104. ex_valid=1 with non-control instruction and ex_pred_target=0x104 -> ex_redirect=0.
- Taken branch at 0x100, target 0x80, pred 0x104 -> ex_redirect=1, redirect_pc=0x80. Next cycle lookup 0x100 -> taken, target 0x80 (ctr=10).
- Same branch resolves not-taken twice -> first: redirect to 0x104, ctr=01. Second, with ex_pred_target=0x104: no redirect, ctr=00. Then three taken resolutions -> ctr 01, 10, 11; a further taken keeps 11.
- jal at 0x200 to 0x400, then jalr at 0x200 to 0x500 -> lookup target becomes 0x400, then 0x500. Each change gives exactly one redirect.
- Aliasing, ENTRIES=16: branch at 0x100 trained taken, then branch at 0x140 (same idx, different tag) taken -> 0x140 overwrites the entry. Lookup 0x100 misses.
- Update and lookup to the same idx in the same cycle -> lookup shows old data, new data appears the next cycle. Assert reset mid-run -> all lookups miss on the following cycle. With BP_STATS_EN: stat counters equal bench-counted values, then 0 after reset.
